hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RV32 core. Sits beside the ID/EX decode path:
//  consumes the 4-bit ALU control code and register fields, and drives PC/pipeline-register
//  enables, flushes and bubbles. Handles load-use stalls, multi-cycle MUL occupancy of EX and
//  taken-branch flushes; keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  MUL_LAT  4   total EX-stage cycles taken by a MUL (legal 1..16; 1 = no stall)
//  CNT_W    16  width of stall_cycles_o
// PORTS
//  clk_i            in   1      clock, all state on rising edge
//  rst_i            in   1      synchronous reset, active-high
//  ifid_rs1_i       in   5      rs1 of instruction in ID
//  ifid_rs2_i       in   5      rs2 of instruction in ID
//  ifid_uses_rs2_i  in   1      ID instruction reads rs2 (R-type, sw, beq)
//  idex_rd_i        in   5      rd of instruction in EX
//  idex_memread_i   in   1      EX instruction is lw
//  idex_aluctrl_i   in   4      ALU control code of EX instruction (4'b0100 = mul)
//  idex_valid_i     in   1      EX holds a real instruction (not bubble)
//  branch_taken_i   in   1      beq in ID resolved taken this cycle
//  pc_write_o       out  1      PC load enable
//  ifid_write_o     out  1      IF/ID register load enable
//  ifid_flush_o     out  1      clear IF/ID to NOP on next edge
//  idex_bubble_o    out  1      load NOP into ID/EX on next edge
//  ex_hold_o        out  1      ID/EX holds its contents (EX occupied)
//  exmem_bubble_o   out  1      load NOP into EX/MEM on next edge
//  mul_busy_o       out  1      FSM in MUL_BUSY
//  stall_cycles_o   out  CNT_W  saturating count of cycles with pc_write_o=0
// BEHAVIOUR
//  - State: FSM {RUN, MUL_BUSY}; 4-bit down-counter mcnt; stall counter. Control outputs are
//    combinational from state, mcnt and inputs; same-cycle response, no added latency.
//  - Reset (rst_i=1 at edge): state<=RUN, mcnt<=0, stall_cycles_o<=0. While rst_i high,
//    outputs forced: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1,
//    ex_hold_o=0, exmem_bubble_o=1, mul_busy_o=0; counter does not increment.
//    Reset mid-MUL aborts the sequence.
//  - Default (RUN, no hazard): pc_write_o=1, ifid_write_o=1, all others 0.
//  - MUL detect: RUN & idex_valid_i & idex_aluctrl_i==4'b0100 & MUL_LAT>1 -> same cycle
//    ex_hold_o=1, exmem_bubble_o=1, pc_write_o=0, ifid_write_o=0; mcnt<=MUL_LAT-2; ->MUL_BUSY.
//  - MUL_BUSY, mcnt!=0: same hold outputs as detect; mcnt<=mcnt-1.
//  - MUL_BUSY, mcnt==0: release (default outputs, subject to hazards below); ->RUN.
//    Net: MUL spends MUL_LAT cycles in EX, MUL_LAT-1 hold cycles; never re-detected.
//  - Load-use (RUN, not MUL-holding): idex_memread_i & idex_rd_i!=0 & (idex_rd_i==ifid_rs1_i
//    | (ifid_uses_rs2_i & idex_rd_i==ifid_rs2_i)) -> pc_write_o=0, ifid_write_o=0,
//    idex_bubble_o=1 for exactly that cycle; clears naturally as lw advances.
//  - Branch: branch_taken_i with no stall active -> ifid_flush_o=1, pc_write_o=1.
//  - Priority: reset > MUL hold > load-use > branch flush. Suppressed branch is re-evaluated
//    next cycle (instruction held in ID). MUL and load-use cannot coincide (one EX instr);
//    if both asserted, MUL wins. x0 never causes a load-use stall.
//  - stall_cycles_o: +1 each non-reset cycle with pc_write_o=0; saturates at all-ones, no wrap.
// TESTING
//  1 rst_i high 2 cycles -> pc_write_o=0, ifid_flush_o=1, stall_cycles_o=0; release -> pc_write_o=1.
//  2 lw x5 in EX, ID rs1=5 -> 1 cycle pc_write_o=0, idex_bubble_o=1; rd=0 or rs2=5 with
//    uses_rs2=0 -> no stall.
//  3 MUL_LAT=4, valid mul in EX -> ex_hold_o=1 for 3 cycles, mul_busy_o=1 cycles 2-4,
//    release cycle 4, stall_cycles_o +3; MUL_LAT=1 -> no hold.
//  4 branch_taken_i during MUL hold -> no flush; flush=1 on first cycle after release.
//  5 rst_i asserted in MUL cycle 2 -> next cycle RUN, mul_busy_o=0, mcnt=0.
//  6 CNT_W=4, 20 stall cycles -> stall_cycles_o holds 4'hF, no wrap.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core.
// Generates PC / IF/ID enables, flushes and bubbles for load-use stalls,
// multi-cycle MUL occupancy of EX and taken-branch flushes, and keeps a
// saturating count of cycles in which the PC was not written.
module hazard_stall_ctrl #(
  parameter int unsigned MUL_LAT = 4,  // total EX cycles of a MUL (1..16)
  parameter int unsigned CNT_W   = 16  // width of stall_cycles_o
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             ifid_uses_rs2_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             idex_memread_i,
  input  logic [3:0]       idex_aluctrl_i,
  input  logic             idex_valid_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             ex_hold_o,
  output logic             exmem_bubble_o,
  output logic             mul_busy_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [0:0] {
    StRun,
    StMulBusy
  } state_e;

  localparam logic [3:0] AluMul = 4'b0100;
  // A single-cycle MUL never needs to hold EX.
  localparam bit         MulStalls = (MUL_LAT > 1);
  // Detect cycle is the first hold cycle, so the countdown covers the rest.
  localparam logic [3:0] MulInit = (MUL_LAT >= 2) ? 4'(MUL_LAT - 2) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       mcnt_q, mcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic mul_detect;
  logic mul_hold;
  logic load_use;

  // Hazard detection terms.
  always_comb begin
    mul_detect = (state_q == StRun) && idex_valid_i && (idex_aluctrl_i == AluMul) && MulStalls;
    mul_hold   = mul_detect || ((state_q == StMulBusy) && (mcnt_q != 4'd0));
    // x0 is hardwired to zero, so a load into it never creates a dependency.
    load_use   = idex_memread_i && (idex_rd_i != 5'd0) &&
                 ((idex_rd_i == ifid_rs1_i) || (ifid_uses_rs2_i && (idex_rd_i == ifid_rs2_i)));
  end

  // Next-state and control outputs; priority reset > MUL hold > load-use > branch.
  always_comb begin
    state_d        = state_q;
    mcnt_d         = mcnt_q;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    ex_hold_o      = 1'b0;
    exmem_bubble_o = 1'b0;
    mul_busy_o     = (state_q == StMulBusy);

    if (rst_i) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = 1'b1;
      exmem_bubble_o = 1'b1;
      mul_busy_o     = 1'b0;
      state_d        = StRun;
      mcnt_d         = 4'd0;
    end else if (mul_hold) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      ex_hold_o      = 1'b1;
      exmem_bubble_o = 1'b1;
      if (mul_detect) begin
        state_d = StMulBusy;
        mcnt_d  = MulInit;
      end else begin
        mcnt_d  = mcnt_q - 4'd1;
      end
    end else begin
      // Release cycle of a MUL (or plain RUN): back to normal sequencing.
      state_d = StRun;
      if (load_use) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

  // Saturating stall-cycle counter; reset cycles are never counted.
  always_comb begin
    stall_d = stall_q;
    if (!pc_write_o && !(&stall_q)) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles_o = stall_q;

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      mcnt_q  <= 4'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Three instances share stimulus:
// a = defaults (MUL_LAT=4, CNT_W=16), b = MUL_LAT=1, c = CNT_W=4.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       uses_rs2, memread, valid, branch;
  logic [3:0] aluctrl;

  logic pc_a, ifw_a, flush_a, bub_a, hold_a, exb_a, busy_a;
  logic pc_b, ifw_b, flush_b, bub_b, hold_b, exb_b, busy_b;
  logic pc_c, ifw_c, flush_c, bub_c, hold_c, exb_c, busy_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .ifid_uses_rs2_i(uses_rs2),
    .idex_rd_i(rd), .idex_memread_i(memread), .idex_aluctrl_i(aluctrl), .idex_valid_i(valid),
    .branch_taken_i(branch), .pc_write_o(pc_a), .ifid_write_o(ifw_a), .ifid_flush_o(flush_a),
    .idex_bubble_o(bub_a), .ex_hold_o(hold_a), .exmem_bubble_o(exb_a), .mul_busy_o(busy_a),
    .stall_cycles_o(cnt_a)
  );

  hazard_stall_ctrl #(.MUL_LAT(1), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .ifid_uses_rs2_i(uses_rs2),
    .idex_rd_i(rd), .idex_memread_i(memread), .idex_aluctrl_i(aluctrl), .idex_valid_i(valid),
    .branch_taken_i(branch), .pc_write_o(pc_b), .ifid_write_o(ifw_b), .ifid_flush_o(flush_b),
    .idex_bubble_o(bub_b), .ex_hold_o(hold_b), .exmem_bubble_o(exb_b), .mul_busy_o(busy_b),
    .stall_cycles_o(cnt_b)
  );

  hazard_stall_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .ifid_uses_rs2_i(uses_rs2),
    .idex_rd_i(rd), .idex_memread_i(memread), .idex_aluctrl_i(aluctrl), .idex_valid_i(valid),
    .branch_taken_i(branch), .pc_write_o(pc_c), .ifid_write_o(ifw_c), .ifid_flush_o(flush_c),
    .idex_bubble_o(bub_c), .ex_hold_o(hold_c), .exmem_bubble_o(exb_c), .mul_busy_o(busy_c),
    .stall_cycles_o(cnt_c)
  );

  // Advance one clock; inputs are changed just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; uses_rs2 = 1'b0; memread = 1'b0;
    valid = 1'b0; branch = 1'b0; aluctrl = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    @(negedge clk);
    checks++; if (pc_a !== 1'b0) begin errors++; $display("FAIL rst_pc got %b want 0", pc_a); end
    checks++; if (flush_a !== 1'b1) begin errors++; $display("FAIL rst_flush got %b want 1", flush_a); end
    checks++; if (bub_a !== 1'b1 || exb_a !== 1'b1) begin errors++;
      $display("FAIL rst_bubbles got %b%b want 11", bub_a, exb_a); end
    checks++; if (hold_a !== 1'b0 || busy_a !== 1'b0 || ifw_a !== 1'b0) begin errors++;
      $display("FAIL rst_hold_busy_ifw got %b%b%b want 000", hold_a, busy_a, ifw_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", cnt_a); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (pc_a !== 1'b1 || ifw_a !== 1'b1) begin errors++;
      $display("FAIL rel_pc_ifw got %b%b want 11", pc_a, ifw_a); end
    checks++; if (flush_a !== 1'b0 || bub_a !== 1'b0 || exb_a !== 1'b0) begin errors++;
      $display("FAIL rel_flush_bub got %b%b%b want 000", flush_a, bub_a, exb_a); end
    tick();
  endtask

  task automatic test_load_use();
    idle(); memread = 1'b1; valid = 1'b1; rd = 5'd5; rs1 = 5'd5;
    @(negedge clk);
    checks++; if (pc_a !== 1'b0 || ifw_a !== 1'b0 || bub_a !== 1'b1) begin errors++;
      $display("FAIL lu_rs1 got pc=%b ifw=%b bub=%b want 0 0 1", pc_a, ifw_a, bub_a); end
    checks++; if (hold_a !== 1'b0 || exb_a !== 1'b0) begin errors++;
      $display("FAIL lu_rs1_hold got %b%b want 00", hold_a, exb_a); end
    tick();
    rs1 = 5'd6; rs2 = 5'd5; uses_rs2 = 1'b0;
    @(negedge clk);
    checks++; if (pc_a !== 1'b1 || bub_a !== 1'b0) begin errors++;
      $display("FAIL lu_rs2_unused got pc=%b bub=%b want 1 0", pc_a, bub_a); end
    checks++; if (cnt_a !== 16'd1) begin errors++; $display("FAIL lu_cnt1 got %0d want 1", cnt_a); end
    tick();
    uses_rs2 = 1'b1;
    @(negedge clk);
    checks++; if (pc_a !== 1'b0 || bub_a !== 1'b1) begin errors++;
      $display("FAIL lu_rs2_used got pc=%b bub=%b want 0 1", pc_a, bub_a); end
    tick();
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    checks++; if (pc_a !== 1'b1 || bub_a !== 1'b0) begin errors++;
      $display("FAIL lu_x0 got pc=%b bub=%b want 1 0", pc_a, bub_a); end
    checks++; if (cnt_a !== 16'd2) begin errors++; $display("FAIL lu_cnt2 got %0d want 2", cnt_a); end
    tick();
  endtask

  task automatic test_branch();
    idle(); branch = 1'b1;
    @(negedge clk);
    checks++; if (flush_a !== 1'b1 || pc_a !== 1'b1 || bub_a !== 1'b0) begin errors++;
      $display("FAIL br_run got flush=%b pc=%b bub=%b want 1 1 0", flush_a, pc_a, bub_a); end
    tick();
    memread = 1'b1; valid = 1'b1; rd = 5'd7; rs1 = 5'd7;
    @(negedge clk);
    checks++; if (flush_a !== 1'b0 || pc_a !== 1'b0 || bub_a !== 1'b1) begin errors++;
      $display("FAIL br_lu got flush=%b pc=%b bub=%b want 0 0 1", flush_a, pc_a, bub_a); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (cnt_a !== 16'd3) begin errors++; $display("FAIL br_cnt got %0d want 3", cnt_a); end
    tick();
  endtask

  task automatic test_mul();
    idle(); valid = 1'b1; aluctrl = 4'b0100;
    @(negedge clk);
    checks++; if (hold_a !== 1'b1 || exb_a !== 1'b1 || pc_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL mul_c1 got hold=%b exb=%b pc=%b busy=%b want 1 1 0 0",
                         hold_a, exb_a, pc_a, busy_a); end
    checks++; if (hold_b !== 1'b0 || pc_b !== 1'b1 || busy_b !== 1'b0) begin errors++;
      $display("FAIL mul_lat1 got hold=%b pc=%b busy=%b want 0 1 0", hold_b, pc_b, busy_b); end
    tick();
    @(negedge clk);
    checks++; if (hold_a !== 1'b1 || busy_a !== 1'b1 || ifw_a !== 1'b0) begin errors++;
      $display("FAIL mul_c2 got hold=%b busy=%b ifw=%b want 1 1 0", hold_a, busy_a, ifw_a); end
    tick();
    @(negedge clk);
    checks++; if (hold_a !== 1'b1 || busy_a !== 1'b1 || pc_a !== 1'b0) begin errors++;
      $display("FAIL mul_c3 got hold=%b busy=%b pc=%b want 1 1 0", hold_a, busy_a, pc_a); end
    tick();
    @(negedge clk);
    checks++; if (hold_a !== 1'b0 || busy_a !== 1'b1 || pc_a !== 1'b1 || exb_a !== 1'b0) begin
      errors++; $display("FAIL mul_c4 got hold=%b busy=%b pc=%b exb=%b want 0 1 1 0",
                         hold_a, busy_a, pc_a, exb_a); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (busy_a !== 1'b0 || pc_a !== 1'b1) begin errors++;
      $display("FAIL mul_c5 got busy=%b pc=%b want 0 1", busy_a, pc_a); end
    checks++; if (cnt_a !== 16'd6) begin errors++; $display("FAIL mul_cnt got %0d want 6", cnt_a); end
    tick();
  endtask

  task automatic test_branch_during_mul();
    idle(); valid = 1'b1; aluctrl = 4'b0100; branch = 1'b1;
    @(negedge clk);
    checks++; if (flush_a !== 1'b0 || hold_a !== 1'b1) begin errors++;
      $display("FAIL bm_c1 got flush=%b hold=%b want 0 1", flush_a, hold_a); end
    checks++; if (flush_b !== 1'b1) begin errors++;
      $display("FAIL bm_lat1_flush got %b want 1", flush_b); end
    tick();
    @(negedge clk);
    checks++; if (flush_a !== 1'b0) begin errors++; $display("FAIL bm_c2 got flush=%b want 0", flush_a); end
    tick();
    @(negedge clk);
    checks++; if (flush_a !== 1'b0) begin errors++; $display("FAIL bm_c3 got flush=%b want 0", flush_a); end
    tick();
    @(negedge clk);
    checks++; if (flush_a !== 1'b1 || pc_a !== 1'b1 || busy_a !== 1'b1) begin errors++;
      $display("FAIL bm_rel got flush=%b pc=%b busy=%b want 1 1 1", flush_a, pc_a, busy_a); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (cnt_a !== 16'd9) begin errors++; $display("FAIL bm_cnt got %0d want 9", cnt_a); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    idle(); valid = 1'b1; aluctrl = 4'b0100;
    tick();
    @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rm_c2 got busy=%b want 1", busy_a); end
    rst = 1'b1;
    #1;
    checks++; if (busy_a !== 1'b0 || hold_a !== 1'b0 || pc_a !== 1'b0 || flush_a !== 1'b1) begin
      errors++; $display("FAIL rm_forced got busy=%b hold=%b pc=%b flush=%b want 0 0 0 1",
                         busy_a, hold_a, pc_a, flush_a); end
    tick();
    rst = 1'b0; idle();
    @(negedge clk);
    checks++; if (busy_a !== 1'b0 || hold_a !== 1'b0 || pc_a !== 1'b1) begin errors++;
      $display("FAIL rm_after got busy=%b hold=%b pc=%b want 0 0 1", busy_a, hold_a, pc_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL rm_cnt got %0d want 0", cnt_a); end
    tick();
    valid = 1'b1; aluctrl = 4'b0100;
    @(negedge clk);
    checks++; if (hold_a !== 1'b1 || busy_a !== 1'b0) begin errors++;
      $display("FAIL rm_redetect got hold=%b busy=%b want 1 0", hold_a, busy_a); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (hold_a !== 1'b1 || busy_a !== 1'b1) begin errors++;
      $display("FAIL rm_full_c3 got hold=%b busy=%b want 1 1", hold_a, busy_a); end
    tick();
    @(negedge clk);
    checks++; if (hold_a !== 1'b0) begin errors++;
      $display("FAIL rm_full_rel got hold=%b want 0", hold_a); end
    tick();
  endtask

  task automatic test_saturation();
    idle(); rst = 1'b1;
    tick();
    rst = 1'b0; memread = 1'b1; valid = 1'b1; rd = 5'd9; rs1 = 5'd9;
    repeat (14) tick();
    @(negedge clk);
    checks++; if (cnt_c !== 4'hE) begin errors++; $display("FAIL sat_14 got %0h want e", cnt_c); end
    tick();
    @(negedge clk);
    checks++; if (cnt_c !== 4'hF) begin errors++; $display("FAIL sat_15 got %0h want f", cnt_c); end
    repeat (5) tick();
    @(negedge clk);
    checks++; if (cnt_c !== 4'hF) begin errors++; $display("FAIL sat_20 got %0h want f", cnt_c); end
    checks++; if (cnt_a !== 16'd20) begin errors++; $display("FAIL sat_wide got %0d want 20", cnt_a); end
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_branch_during_mul();
    test_reset_mid_mul();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
